sevenseg_capture_decoder: RTL and testbench
===========================================

# sevenseg_capture_decoder

Captures a multiplexed, active-low seven-segment display bus (digit enables plus shared segment lines) and recovers the hex value being shown. It performs the inverse of the team's 4-bit-to-7-segment encoder: it qualifies each digit's pattern for stability, decodes it back to a nibble, and assembles a full multi-digit word. It sits on the display side of the board as a loop-back monitor, used for self-check of the display path and for bench readback.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; range 1–8.
- STABLE_CNT, 3, consecutive identical qualified samples required to accept a digit; minimum 1.
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- sample_en  input  1  sample strobe; the bus is examined only on cycles where this is 1.
- an_n  input  NUM_DIGITS  active-low digit enables; bit i low selects digit i (digit 0 is least significant).
- seg_in  input  7  active-low segments; bit0=a … bit6=g (a pattern of 1000000 is "0").
- value_out  output  4*NUM_DIGITS  last complete decoded word; digit i occupies [4i+3:4i].
- valid_out  output  1  one-cycle pulse when value_out is updated.
- frame_err  output  1  set with valid_out if any digit in that frame was undecodable; holds until the next frame update.
- digit_err  output  NUM_DIGITS  per-digit error flags for the last frame; updated with valid_out.

## Operation
- A sample is qualified when sample_en=1 and exactly one bit of an_n is 0.
  - all-ones an_n is blanking; more than one low bit is illegal.
  - both non-qualified cases force the FSM to S_IDLE and do nothing else.
- Digit tracker FSM. Only cycles with sample_en=1 change state; sample_en=0 holds all state.
  - S_IDLE: on a qualified sample, latch (digit index, seg_in), set cnt=1, and go to S_COUNT.
    - If STABLE_CNT=1, accept immediately and go to S_HELD.
  - S_COUNT, same (index, seg_in) as latched: increment cnt. When cnt reaches STABLE_CNT, accept and go to S_HELD.
  - S_COUNT, different (index, seg_in): re-latch, cnt=1, stay in S_COUNT (accept immediately if STABLE_CNT=1).
  - S_HELD, same (index, seg_in): no action. A digit is accepted at most once per dwell.
  - S_HELD, different (index, seg_in): re-latch, cnt=1, go to S_COUNT (or accept immediately if STABLE_CNT=1).
- Decode rule for an accepted pattern:
  - The 16 legal patterns map to nibbles 0x0–0xF: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
  - Any other pattern, including blank 1111111, is invalid.
- Acceptance of digit i:
  - Valid pattern: write the decoded nibble to shadow[i] and clear shadow_err[i].
  - Invalid pattern: write 0 to shadow[i] and set shadow_err[i].
  - In both cases set seen[i].
  - A repeat acceptance of digit i before the frame completes overwrites shadow[i] and shadow_err[i].
- Frame completion: when an acceptance makes seen all-ones:
  - value_out ← shadow, including the nibble accepted on this edge.
  - digit_err ← shadow_err, likewise including this edge.
  - frame_err ← OR of the new digit_err.
  - valid_out=1 for one cycle; seen is cleared.
- Digits may arrive in any order. Frame completion is defined only by the seen mask.

## Timing
- Reset (rst_n=0 at an edge) values:
  - value_out=0, valid_out=0, frame_err=0, digit_err=0.
  - seen=0, shadow=0, shadow_err=0, cnt=0, FSM=S_IDLE.
  - Reset mid-frame discards the partial frame.
- Acceptance latency: acceptance occurs on the edge that samples the STABLE_CNT-th consecutive matching qualified sample.
- Output latency: value_out, digit_err, frame_err and valid_out are registered, visible in the cycle after the completing edge. valid_out is 1 for exactly that cycle.
- Non-qualified samples with sample_en=1 break a dwell. sample_en=0 gaps do not break it.
- Back-to-back frames: valid_out may pulse on any edge where seen completes. There is no minimum spacing beyond NUM_DIGITS*STABLE_CNT samples.
- No handshake: valid_out is not held, and a missed pulse is lost. value_out persists until the next frame.

## Test plan
- Reset, then NUM_DIGITS=4, STABLE_CNT=3: scan digits 0..3 showing 1111000, 0000011, 1000110, 0010010, each held for 3 sample_en cycles -> one valid_out pulse after digit 3's third sample; value_out=0x5Cb7 (0x5CB7); frame_err=0.
- Same scan with each digit held only 2 samples -> no acceptance, valid_out never asserts, value_out stays 0.
- Digit 2 shows 1111111 for 3 samples, others legal -> valid_out pulses; digit_err=0100; frame_err=1; nibble 2 = 0.
- Digit 1 held for 9 consecutive samples within a full scan -> accepted once; exactly one valid_out per scan; value matches.
- Mid-count, insert one sample with an_n=1111 (sample_en=1), then resume the same digit -> count restarts, so 3 further matching samples are needed.
- Assert rst_n=0 after digits 0–2 are accepted, then scan only digit 3 -> no valid_out; all outputs stay 0.

Source files
------------

// File: rtl/sevenseg_capture_decoder_if.sv
// Seven-segment capture bus: display-side inputs plus decoded word outputs.
// master drives the display bus and reads results; slave is the decoder.
interface sevenseg_capture_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    sample_en;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_in;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic                    valid_out;
  logic                    frame_err;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output sample_en, an_n, seg_in,
    input  value_out, valid_out, frame_err, digit_err
  );

  modport slave (
    input  sample_en, an_n, seg_in,
    output value_out, valid_out, frame_err, digit_err
  );
endinterface

// File: rtl/sevenseg_capture_decoder.sv
// Recovers the hex word shown on a multiplexed active-low 7-seg bus.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of the _if).
module sevenseg_capture_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input logic clk,
  input logic rst_n,
  sevenseg_capture_decoder_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] SC_V = CW'(STABLE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_HELD
  } state_t;

  state_t                  state;
  logic [IW-1:0]           lat_idx;
  logic [6:0]              lat_seg;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [4*NUM_DIGITS-1:0] shadow;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [NUM_DIGITS-1:0]   an_low;
  logic                    one_low;
  logic [IW-1:0]           idx;
  logic                    same;
  logic                    fresh;
  logic [CW-1:0]           cnt_inc;
  logic                    accept;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   seen_n;
  logic [NUM_DIGITS-1:0]   err_n;
  logic [4*NUM_DIGITS-1:0] shadow_n;
  logic                    complete;

  assign an_low  = ~bus.an_n;
  // Exactly one digit enable low: nonzero and a power of two.
  assign one_low = (an_low != '0) &&
                   ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_low[i]) idx = IW'(i);
  end

  assign same    = (idx == lat_idx) && (bus.seg_in == lat_seg);
  assign fresh   = (state == S_IDLE) || !same;
  assign cnt_inc = cnt + CW'(1);
  assign accept  = bus.sample_en && one_low &&
                   (fresh ? (STABLE_CNT == 1)
                          : (state == S_COUNT && cnt_inc == SC_V));
  assign dec     = decode(bus.seg_in);

  always_comb begin
    seen_n   = seen | (NUM_DIGITS'(1) << idx);
    err_n    = shadow_err;
    shadow_n = shadow;
    err_n[idx] = !dec[4];
    shadow_n[4*int'(idx) +: 4] = dec[4] ? dec[3:0] : 4'h0;
  end

  assign complete = &seen_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lat_idx       <= '0;
      lat_seg       <= '0;
      cnt           <= '0;
      seen          <= '0;
      shadow        <= '0;
      shadow_err    <= '0;
      bus.value_out <= '0;
      bus.valid_out <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.digit_err <= '0;
    end else begin
      bus.valid_out <= 1'b0;
      if (bus.sample_en) begin
        if (!one_low) begin
          state <= S_IDLE;
        end else if (fresh) begin
          lat_idx <= idx;
          lat_seg <= bus.seg_in;
          cnt     <= CW'(1);
          state   <= (STABLE_CNT == 1) ? S_HELD : S_COUNT;
        end else if (state == S_COUNT) begin
          cnt <= cnt_inc;
          if (cnt_inc == SC_V) state <= S_HELD;
        end
      end
      if (accept) begin
        shadow     <= shadow_n;
        shadow_err <= err_n;
        if (complete) begin
          seen          <= '0;
          bus.value_out <= shadow_n;
          bus.digit_err <= err_n;
          bus.frame_err <= |err_n;
          bus.valid_out <= 1'b1;
        end else begin
          seen <= seen_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_capture_decoder.sv
// Directed bench for sevenseg_capture_decoder with a run-length model.
// Model output is compared every cycle; literals pin key scenarios.
module tb_sevenseg_capture_decoder;
  localparam int ND = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_capture_decoder_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_capture_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CNT(SC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a digit is accepted when its run of identical qualified
  // samples reaches exactly SC; the frame closes when all digits seen.
  int         run = 0;
  int         m_idx = 0;
  int         md;
  logic [6:0] m_seg = '0;
  logic [3:0] sh [ND];
  bit         se [ND];
  bit         sn [ND];
  logic [15:0] e_val = '0;
  logic [3:0]  e_derr = '0;
  logic        e_ferr = 1'b0;
  logic        e_valid = 1'b0;

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic m_accept(input int d, input logic [6:0] s);
    int k;
    bit all;
    k = lookup(s);
    sh[d] = (k < 0) ? 4'h0 : 4'(k);
    se[d] = (k < 0);
    sn[d] = 1;
    all = 1;
    for (int i = 0; i < ND; i++)
      if (!sn[i]) all = 0;
    if (all) begin
      for (int i = 0; i < ND; i++) begin
        e_val[4*i +: 4] = sh[i];
        e_derr[i] = se[i];
        sn[i] = 0;
      end
      e_ferr = |e_derr;
      e_valid = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      run = 0;
      for (int i = 0; i < ND; i++) begin
        sh[i] = '0; se[i] = 0; sn[i] = 0;
      end
      e_val = '0; e_derr = '0; e_ferr = 0; e_valid = 0;
    end else begin
      e_valid = 0;
      if (bus.sample_en) begin
        if ($countones(~bus.an_n) == 1) begin
          md = 0;
          for (int i = 0; i < ND; i++)
            if (!bus.an_n[i]) md = i;
          if (run > 0 && md == m_idx && bus.seg_in == m_seg) begin
            run++;
          end else begin
            run = 1;
            m_idx = md;
            m_seg = bus.seg_in;
          end
          if (run == SC) m_accept(md, bus.seg_in);
        end else begin
          run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(bus.valid_out), 32'(e_valid));
      chk("value", 32'(bus.value_out), 32'(e_val));
      chk("digit_err", 32'(bus.digit_err), 32'(e_derr));
      chk("frame_err", 32'(bus.frame_err), 32'(e_ferr));
      if (bus.valid_out === 1'b1) pulses++;
    end
  end

  task automatic drive(input bit en, input logic [3:0] an,
                       input logic [6:0] s);
    @(negedge clk);
    #1;
    bus.sample_en = en;
    bus.an_n = an;
    bus.seg_in = s;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [3:0] a;
    a = 4'b1 << d;
    repeat (n) drive(1'b1, ~a, s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'hF, 7'h7F);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.sample_en = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int n, input logic [6:0] p0,
                      input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3);
    show(0, p0, n);
    show(1, p1, n);
    show(2, p2, n);
    show(3, p3, n);
  endtask

  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] BL = 7'b1111111;

  int p0;

  initial begin
    bus.sample_en = 1'b0;
    bus.an_n = 4'hF;
    bus.seg_in = 7'h7F;
    do_reset();
    idle(1);
    chk("rst_value", 32'(bus.value_out), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_derr", 32'(bus.digit_err), 32'h0);

    p0 = pulses;
    scan(3, P7, PB, PC, P5);
    idle(2);
    chk("t1_pulses", 32'(pulses - p0), 32'd1);
    chk("t1_value", 32'(bus.value_out), 32'h5CB7);
    chk("t1_ferr", 32'(bus.frame_err), 32'h0);
    chk("t1_model", 32'(e_val), 32'h5CB7);

    do_reset();
    p0 = pulses;
    scan(2, P7, PB, PC, P5);
    idle(2);
    chk("t2_pulses", 32'(pulses - p0), 32'd0);
    chk("t2_value", 32'(bus.value_out), 32'h0);

    p0 = pulses;
    scan(3, P7, PB, BL, P5);
    idle(2);
    chk("t3_pulses", 32'(pulses - p0), 32'd1);
    chk("t3_value", 32'(bus.value_out), 32'h50B7);
    chk("t3_derr", 32'(bus.digit_err), 32'b0100);
    chk("t3_ferr", 32'(bus.frame_err), 32'h1);
    chk("t3_model", 32'(e_derr), 32'b0100);

    p0 = pulses;
    show(0, P7, 3);
    show(1, PB, 4);
    idle(2);
    show(1, PB, 5);
    show(2, PC, 3);
    show(3, P5, 3);
    idle(2);
    chk("t4_pulses", 32'(pulses - p0), 32'd1);
    chk("t4_value", 32'(bus.value_out), 32'h5CB7);
    chk("t4_ferr", 32'(bus.frame_err), 32'h0);

    p0 = pulses;
    show(0, P8, 2);
    drive(1'b1, 4'hF, P8);
    show(0, P8, 2);
    show(1, PB, 3);
    show(2, PC, 3);
    show(3, P5, 3);
    idle(2);
    chk("t5_no_pulse", 32'(pulses - p0), 32'd0);
    show(0, P8, 3);
    idle(2);
    chk("t5_pulses", 32'(pulses - p0), 32'd1);
    chk("t5_value", 32'(bus.value_out), 32'h5CB8);

    do_reset();
    p0 = pulses;
    show(0, P7, 3);
    show(1, PB, 3);
    show(2, PC, 3);
    do_reset();
    show(3, P5, 3);
    idle(2);
    chk("t6_pulses", 32'(pulses - p0), 32'd0);
    chk("t6_value", 32'(bus.value_out), 32'h0);
    chk("t6_derr", 32'(bus.digit_err), 32'h0);
    chk("t6_ferr", 32'(bus.frame_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
